// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the PC and issues one word read per cycle to a
// 1-cycle-latency instruction memory. Returned words are buffered with their
// PC in a small FIFO and handed to decode over a valid/ready handshake.
// A redirect flushes buffered and in-flight fetches.
// Ports:
//   clk_i, rst_i              clock, async active-high reset
//   imem_en_o, imem_addr_o    memory read request (word aligned)
//   imem_inst_i               read data, valid the cycle after a request
//   redirect_i, redirect_pc_i control-flow change and its target
//   inst_valid_o, inst_o,
//   inst_pc_o, inst_ready_i   decode handshake
//   perf_fetched_o,
//   perf_stall_o              only with IFETCH_PERF_EN: pop / stall counters
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_en_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_inst_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  input  logic        inst_ready_i
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched_o,
  output logic [31:0] perf_stall_o
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  logic [31:0]   r_pc;
  logic [31:0]   r_req_pc;
  logic          r_inflight;
  logic [31:0]   r_buf_inst [FIFO_DEPTH];
  logic [31:0]   r_buf_pc   [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic          w_pop;
  logic          w_push;
  logic [CW:0]   w_credit;
  logic          w_unused;

  assign w_unused = ^redirect_pc_i[1:0];

  assign w_pop  = inst_valid_o & inst_ready_i;
  assign w_push = r_inflight & ~redirect_i;

  // Slots committed after this cycle: buffered plus in-flight, minus the
  // entry leaving now. One extra bit keeps the sum from wrapping.
  assign w_credit = {1'b0, r_count}
                  + {{CW{1'b0}}, r_inflight}
                  - {{CW{1'b0}}, w_pop};

  assign imem_en_o   = ~rst_i & ~redirect_i & (w_credit < DEPTH_C);
  assign imem_addr_o = r_pc;

  assign inst_valid_o = (r_count != '0);
  assign inst_o       = r_buf_inst[r_rptr];
  assign inst_pc_o    = r_buf_pc[r_rptr];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pc       <= RESET_PC;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_buf_inst[i] <= '0;
        r_buf_pc[i]   <= '0;
      end
    end else if (redirect_i) begin
      r_pc       <= {redirect_pc_i[31:2], 2'b00};
      r_inflight <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
    end else begin
      r_inflight <= imem_en_o;
      if (imem_en_o) begin
        r_pc     <= r_pc + 32'd4;
        r_req_pc <= r_pc;
      end
      if (w_push) begin
        r_buf_inst[r_wptr] <= imem_inst_i;
        r_buf_pc[r_wptr]   <= r_req_pc;
        r_wptr             <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_fetched_o <= '0;
      perf_stall_o   <= '0;
    end else begin
      if (w_pop) begin
        perf_fetched_o <= perf_fetched_o + 32'd1;
      end
      if (inst_valid_o && !inst_ready_i) begin
        perf_stall_o <= perf_stall_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch: directed steps with a PC scoreboard.
// A second instance covers PC wrap from RESET_PC=32'hFFFF_FFF8.
module tb_instruction_fetch;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ready;

  logic        en, en2;
  logic [31:0] addr, addr2, mem, mem2;
  logic        valid, valid2;
  logic [31:0] inst, inst2, pc, pc2;
`ifdef IFETCH_PERF_EN
  logic [31:0] pf_fetch, pf_stall, pf_fetch2, pf_stall2;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [31:0] q[$];
  logic [31:0] sb_e;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .imem_en_o     (en),
    .imem_addr_o   (addr),
    .imem_inst_i   (mem),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .inst_valid_o  (valid),
    .inst_o        (inst),
    .inst_pc_o     (pc),
    .inst_ready_i  (ready)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetched_o(pf_fetch),
    .perf_stall_o  (pf_stall)
`endif
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk_i         (clk),
    .rst_i         (rst),
    .imem_en_o     (en2),
    .imem_addr_o   (addr2),
    .imem_inst_i   (mem2),
    .redirect_i    (1'b0),
    .redirect_pc_i (32'h0),
    .inst_valid_o  (valid2),
    .inst_o        (inst2),
    .inst_pc_o     (pc2),
    .inst_ready_i  (ready)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetched_o(pf_fetch2),
    .perf_stall_o  (pf_stall2)
`endif
  );

  always @(posedge clk) begin
    mem  <= en  ? (addr  ^ K) : 32'hBAD0_BAD0;
    mem2 <= en2 ? (addr2 ^ K) : 32'hBAD0_BAD0;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && valid && ready) begin
      checks++;
      assert (q.size() != 0) else begin
        errors++;
        $error("FAIL sb_extra: observed pc %h expected none", pc);
      end
      if (q.size() != 0) begin
        sb_e = q.pop_front();
        chk("sb_pc", pc, sb_e);
        chk("sb_inst", inst, sb_e ^ K);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_end(input string tag);
    checks++;
    assert (q.size() == 0) else begin
      errors++;
      $error("FAIL %s: observed %0d undelivered expected 0", tag, q.size());
    end
    q.delete();
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect = 1'b0;
    redirect_pc = '0;
    ready = 1'b0;
    step();
    chk("rst_valid", valid, 0);
    chk("rst_en", en, 0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_addr2", addr2, 32'hFFFF_FFF8);
`ifdef IFETCH_PERF_EN
    chk("rst_pf_fetch", pf_fetch, 0);
    chk("rst_pf_stall", pf_stall, 0);
`endif
    release_rst();
  endtask

  initial begin
    rst = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    ready = 1'b0;
    #2;

    // Streaming after reset, plus wrap on the second instance
    do_reset();
    ready = 1'b1;
    q = '{32'h0, 32'h4, 32'h8, 32'hC};
    #1;
    chk("a0_en", en, 1);
    chk("a0_addr", addr, 32'h0);
    chk("a0_valid", valid, 0);
    step();
    chk("a1_en", en, 1);
    chk("a1_addr", addr, 32'h4);
    chk("a1_valid", valid, 0);
    step();
    chk("a2_valid", valid, 1);
    chk("a2_pc", pc, 32'h0);
    chk("a2_en", en, 1);
    chk("w2_pc", pc2, 32'hFFFF_FFF8);
    step();
    chk("a3_en", en, 1);
    chk("w3_pc", pc2, 32'hFFFF_FFFC);
    step();
    chk("a4_en", en, 1);
    chk("w4_pc", pc2, 32'h0);
    chk("w4_valid", valid2, 1);
    step();
    chk("a5_en", en, 1);
    step();
    ready = 1'b0;
    sb_end("a_end");

    // Backpressure for 5 cycles from cycle 2
    do_reset();
    ready = 1'b1;
    step();
    step();
    ready = 1'b0;
    #1;
    chk("b2_valid", valid, 1);
    chk("b2_pc", pc, 32'h0);
    chk("b2_en", en, 0);
    for (int i = 3; i < 7; i++) begin
      step();
      chk("b_hold_valid", valid, 1);
      chk("b_hold_pc", pc, 32'h0);
      chk("b_hold_en", en, 0);
    end
    step();
    q = '{32'h0, 32'h4, 32'h8};
    ready = 1'b1;
    #1;
    chk("b7_en", en, 1);
    step();
    step();
    step();
    ready = 1'b0;
    sb_end("b_end");

    // Redirect at cycle 6 to 0x103
    do_reset();
    ready = 1'b1;
    q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    repeat (6) step();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    #1;
    chk("c6_en", en, 0);
    chk("c6_pc", pc, 32'h10);
    step();
    redirect = 1'b0;
    #1;
    chk("c7_en", en, 1);
    chk("c7_addr", addr, 32'h100);
    chk("c7_valid", valid, 0);
    step();
    chk("c8_valid", valid, 0);
    step();
    chk("c9_valid", valid, 1);
    chk("c9_pc", pc, 32'h100);
    q.push_back(32'h100);
    q.push_back(32'h104);
    step();
    step();
    ready = 1'b0;
    sb_end("c_end");

    // Redirect coincident with pop on a full FIFO
    do_reset();
    ready = 1'b1;
    step();
    step();
    ready = 1'b0;
    step();
    step();
    q = '{32'h0};
    ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h200;
    #1;
    chk("d4_en", en, 0);
    chk("d4_valid", valid, 1);
    step();
    redirect = 1'b0;
    #1;
    chk("d5_valid", valid, 0);
    chk("d5_en", en, 1);
    chk("d5_addr", addr, 32'h200);
    step();
    chk("d6_valid", valid, 0);
    step();
    chk("d7_valid", valid, 1);
    chk("d7_pc", pc, 32'h200);
    q.push_back(32'h200);
    step();
    ready = 1'b0;
    sb_end("d_end");

    // Back-to-back redirects, the last one wins
    do_reset();
    ready = 1'b1;
    q = '{32'h0, 32'h4};
    step();
    step();
    step();
    redirect = 1'b1;
    redirect_pc = 32'h300;
    #1;
    chk("e3_en", en, 0);
    chk("e3_pc", pc, 32'h4);
    step();
    redirect_pc = 32'h404;
    #1;
    chk("e4_en", en, 0);
    chk("e4_valid", valid, 0);
    step();
    redirect = 1'b0;
    #1;
    chk("e5_en", en, 1);
    chk("e5_addr", addr, 32'h404);
    step();
    step();
    chk("e7_valid", valid, 1);
    chk("e7_pc", pc, 32'h404);
    q.push_back(32'h404);
    step();
    ready = 1'b0;
    sb_end("e_end");

    // Async reset with two entries buffered
    do_reset();
    ready = 1'b1;
    step();
    step();
    ready = 1'b0;
    step();
    chk("g3_valid", valid, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("g_rst_valid", valid, 0);
    chk("g_rst_en", en, 0);
    chk("g_rst_addr", addr, 32'h0);
    release_rst();
    ready = 1'b1;
    q = '{32'h0};
    step();
    step();
    chk("g2_valid", valid, 1);
    chk("g2_pc", pc, 32'h0);
    step();
    ready = 1'b0;
    sb_end("g_end");

    // 3 stall cycles followed by 10 pops
    do_reset();
    ready = 1'b1;
    step();
    step();
    ready = 1'b0;
    step();
    step();
    step();
    for (int i = 0; i < 10; i++) q.push_back(32'(i * 4));
    ready = 1'b1;
    repeat (10) step();
    ready = 1'b0;
    #1;
`ifdef IFETCH_PERF_EN
    chk("pf_fetched", pf_fetch, 32'd10);
    chk("pf_stall", pf_stall, 32'd3);
`endif
    chk("f_valid", valid, 1);
    chk("f_pc", pc, 32'h28);
    sb_end("f_end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
